// File: rtl/data_collector_if.sv
// data_collector_if: four-channel valid/ready producer side plus one tagged output stream.
`default_nettype none

interface data_collector_if #(
  parameter int WIDTH = 8
);
  logic               enable;
  logic [3:0]         in_valid;
  logic [4*WIDTH-1:0] in_data;
  logic [3:0]         in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [1:0]         out_sel;
  logic               out_ready;

  // Driver side: producers, consumer and enable control
  modport master (
    output enable, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  // Collector side
  modport slave (
    input  enable, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );
endinterface

`default_nettype wire

// File: rtl/data_collector.sv
// data_collector: 4-to-1 round-robin merge with a single registered output stage.
// Define DATA_COLLECTOR_FIXED_PRIO_EN for fixed priority (channel 0 highest).
`default_nettype none

module data_collector #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  data_collector_if.slave  bus
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [1:0]       r_sel;
  logic [1:0]       w_start;
  logic [1:0]       w_grant;
  logic [1:0]       w_idx;
  logic             w_found;
  logic             w_load;

`ifdef DATA_COLLECTOR_FIXED_PRIO_EN
  assign w_start = 2'd0;
`else
  logic [1:0] r_ptr;
  assign w_start = r_ptr;
`endif

  // First valid channel starting from w_start, wrapping mod 4
  always_comb begin
    w_grant = 2'd0;
    w_found = 1'b0;
    w_idx   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      w_idx = w_start + 2'(k);
      if (!w_found && bus.in_valid[w_idx]) begin
        w_grant = w_idx;
        w_found = 1'b1;
      end
    end
  end

  assign w_load       = bus.enable && (!r_valid || bus.out_ready) && w_found;
  assign bus.in_ready = w_load ? (4'b0001 << w_grant) : 4'b0000;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sel   <= 2'd0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_data  <= bus.in_data[int'(w_grant)*WIDTH +: WIDTH];
      r_sel   <= w_grant;
    end else if (bus.out_ready) begin
      r_valid <= 1'b0;
    end
  end

`ifndef DATA_COLLECTOR_FIXED_PRIO_EN
  // Pointer moves just past the winner, so it has lowest priority next time
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= 2'd0;
    end else if (w_load) begin
      r_ptr <= w_grant + 2'd1;
    end
  end
`endif

  assign bus.out_valid = r_valid;
  assign bus.out_data  = r_data;
  assign bus.out_sel   = r_sel;

endmodule

`default_nettype wire

// File: tb/tb_data_collector.sv
// tb_data_collector: directed stimulus with an expected-beat queue checked by a separate output monitor.
`default_nettype none

module tb_data_collector;

  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [9:0] exp_q[$];

  data_collector_if #(.WIDTH(WIDTH)) bus ();

  data_collector #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_ch(input int ch, input logic [7:0] d);
    bus.in_data[ch*WIDTH +: WIDTH] = d;
  endtask

  // Expect grant of channel ch this cycle and the matching output beat later
  task automatic expect_grant(input string name, input logic [1:0] ch, input logic [7:0] d);
    #1;
    chk(name, {28'd0, bus.in_ready}, 32'(4'b0001 << ch));
    exp_q.push_back({ch, d});
  endtask

  // Output monitor: every completed output transfer must match the queue head
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_beat: got sel=%0d data=%0h expected no beat", bus.out_sel, bus.out_data);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        if ({bus.out_sel, bus.out_data} !== e) begin
          errors++;
          $display("FAIL out_beat: got sel=%0d data=%0h expected sel=%0d data=%0h",
                   bus.out_sel, bus.out_data, e[9:8], e[7:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.enable    = 1'b0;
    bus.in_valid  = 4'b0000;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // Reset and single beat
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, bus.out_data}, 32'd0);
    chk("rst_out_sel", {30'd0, bus.out_sel}, 32'd0);
    cyc();
    bus.enable = 1'b1; bus.out_ready = 1'b1;
    bus.in_valid = 4'b0100; set_ch(2, 8'hA5);
    expect_grant("single_rdy", 2'd2, 8'hA5);
    cyc();
    chk("single_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("single_data", {24'd0, bus.out_data}, 32'hA5);
    chk("single_sel", {30'd0, bus.out_sel}, 32'd2);
    // Pointer now 3: channel 3 beats channel 0
    bus.in_valid = 4'b1001; set_ch(0, 8'h50); set_ch(3, 8'h53);
    expect_grant("ptr3_rdy", 2'd3, 8'h53);
    cyc();
    bus.in_valid = 4'b0001;
    expect_grant("ptr0_rdy", 2'd0, 8'h50);
    cyc();
    bus.in_valid = 4'b0000;
    cyc();

    // Round-robin rotation from a fresh pointer
    rst = 1'b1; #2; rst = 1'b0;
    bus.in_valid = 4'b1111;
    for (int i = 0; i < 4; i++) set_ch(i, 8'h10 + 8'(i));
    for (int i = 0; i < 5; i++) begin
      expect_grant("rr_rdy", 2'(i % 4), 8'h10 + 8'(i % 4));
      cyc();
    end
    bus.in_valid = 4'b0000;
    cyc();

    // Backpressure with pointer at 1
    bus.in_valid = 4'b0010; set_ch(1, 8'h3C);
    expect_grant("bp_first_rdy", 2'd1, 8'h3C);
    cyc();
    bus.out_ready = 1'b0;
    bus.in_valid = 4'b0001; set_ch(0, 8'h4D);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_stall_rdy", {28'd0, bus.in_ready}, 32'd0);
      chk("bp_hold_data", {24'd0, bus.out_data}, 32'h3C);
      chk("bp_hold_sel", {30'd0, bus.out_sel}, 32'd1);
      chk("bp_hold_valid", {31'd0, bus.out_valid}, 32'd1);
      cyc();
    end
    bus.out_ready = 1'b1;
    expect_grant("bp_release_rdy", 2'd0, 8'h4D);
    cyc();
    chk("bp_nobubble_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("bp_nobubble_data", {24'd0, bus.out_data}, 32'h4D);
    bus.in_valid = 4'b0000;
    cyc();

    // Enable gating: pending 0x77 drains, channel 3 never accepted
    bus.out_ready = 1'b0;
    bus.in_valid = 4'b0100; set_ch(2, 8'h77);
    expect_grant("en_load_rdy", 2'd2, 8'h77);
    cyc();
    bus.enable = 1'b0;
    bus.in_valid = 4'b1000; set_ch(3, 8'h88);
    #1;
    chk("en_off_rdy_stall", {28'd0, bus.in_ready}, 32'd0);
    cyc();
    bus.out_ready = 1'b1;
    #1;
    chk("en_off_rdy_drain", {28'd0, bus.in_ready}, 32'd0);
    cyc();
    chk("en_off_valid_fall", {31'd0, bus.out_valid}, 32'd0);
    chk("en_off_rdy_idle", {28'd0, bus.in_ready}, 32'd0);
    cyc();
    chk("en_off_valid_stay", {31'd0, bus.out_valid}, 32'd0);
    bus.in_valid = 4'b0000;
    bus.enable = 1'b1;
    cyc();

    // Reset mid-operation while stalled: the pending beat is discarded
    bus.out_ready = 1'b0;
    bus.in_valid = 4'b0001; set_ch(0, 8'h99);
    #1;
    chk("mid_load_rdy", {28'd0, bus.in_ready}, 32'd1);
    cyc();
    bus.in_valid = 4'b0000;
    chk("mid_stall_valid", {31'd0, bus.out_valid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("mid_rst_data", {24'd0, bus.out_data}, 32'd0);
    chk("mid_rst_sel", {30'd0, bus.out_sel}, 32'd0);
    cyc();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    cyc();

    // Channels 0 and 3 continuously valid
    bus.in_valid = 4'b1001; set_ch(0, 8'hC0); set_ch(3, 8'hC3);
    for (int i = 0; i < 4; i++) begin
`ifdef DATA_COLLECTOR_FIXED_PRIO_EN
      expect_grant("prio_rdy", 2'd0, 8'hC0);
`else
      if (i % 2 == 0) expect_grant("rr03_rdy", 2'd0, 8'hC0);
      else            expect_grant("rr03_rdy", 2'd3, 8'hC3);
`endif
      cyc();
    end
    bus.in_valid = 4'b0000;
    cyc(); cyc();

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/data_collector.md
# data_collector

Four-channel, 8-bit round-robin data collector with valid/ready handshakes on every channel. It merges up to four producer streams into one output stream and tags each beat with its source channel. It is the gathering counterpart to the team's 1-to-4 data distributor, which fans a stream out by channel index: `out_sel` here carries the same 2-bit channel encoding. The block has a single registered output stage.

## Interface
- `WIDTH`, 8, data width per channel.
- `clk  input  1  rising-edge clock`
- `rst  input  1  asynchronous, active-high reset`
- `enable  input  1  1 = accept new input beats; 0 = accept nothing`
- `in_valid  input  4  per-channel valid; bit i = channel i`
- `in_data  input  4*WIDTH  channel i data at [i*WIDTH +: WIDTH]`
- `in_ready  output  4  per-channel ready (combinational); at most one bit high`
- `out_valid  output  1  output beat valid (registered)`
- `out_data  output  WIDTH  output beat data (registered)`
- `out_sel  output  2  source channel of output beat (registered)`
- `out_ready  input  1  consumer ready`

## Operation
- Reset values: `out_valid`=0, `out_data`=0, `out_sel`=2'b00, internal round-robin pointer `ptr`=0.
- `load` = `enable` && (!`out_valid` || `out_ready`) && (|`in_valid`).
- Grant `g` is the first channel with `in_valid` set, searched in the order `ptr`, `ptr`+1, `ptr`+2, `ptr`+3 (mod 4).
- `in_ready[g]` = `load`. All other `in_ready` bits are 0. `in_ready` never asserts for a channel whose `in_valid` is low.
- A channel i transfer occurs when `in_valid[i]` && `in_ready[i]`. On that clock edge:
  - `out_data` <= channel i data
  - `out_sel` <= i
  - `out_valid` <= 1
  - `ptr` <= (i+1) mod 4
- An output transfer occurs when `out_valid` && `out_ready`. If no `load` happens in the same cycle, `out_valid` <= 0. `out_data` and `out_sel` keep their last value.
- Simultaneous output transfer and `load` in one cycle: the new beat replaces the old one with no bubble, and `out_valid` stays 1.
- While `out_valid` && !`out_ready` (stall): `out_data` and `out_sel` are held stable and all `in_ready` bits are 0.
- `enable` low:
  - No new acceptance; `ptr` is frozen.
  - A pending output beat is still presented and drains normally.
- Reset asserted mid-operation: all state returns to reset values immediately. Any pending output beat is lost.
- Producers must hold `in_valid` and data stable until their transfer completes. A drop of `in_valid` before transfer is tolerated: that channel is simply not granted.

## Timing
- Latency: input transfer at edge N means `out_valid` and the data are visible after edge N. Output transfer is possible in cycle N+1.
- Throughput: one beat per cycle when `out_ready` is held high.
- Fairness: with all four channels valid continuously, grants rotate 0,1,2,3,0,… One full rotation completes in 4 beats.
- `in_ready` depends combinationally on `out_ready`, `enable`, `in_valid` and `ptr`. There is no combinational path from `in_data` to any output.

## Configuration
- `DATA_COLLECTOR_FIXED_PRIO_EN` defined: fixed priority, channel 0 highest and channel 3 lowest. The search always starts at channel 0 and `ptr` is not used. A continuously valid channel 0 starves the others.
- Not defined (default): round-robin arbitration exactly as described above.

## Test plan
- Reset and single beat:
  - Stimulus: assert `rst`; then channel 2 valid with 0xA5, `enable`=1, `out_ready`=1.
  - Required: `in_ready`=4'b0100 in that cycle; next cycle `out_valid`=1, `out_data`=0xA5, `out_sel`=2; `ptr` becomes 3.
- Round-robin rotation:
  - Stimulus: all channels valid with 0x10/0x11/0x12/0x13, `out_ready`=1.
  - Required: `out_sel` sequence 0,1,2,3,0 on consecutive cycles, with matching data.
- Backpressure:
  - Stimulus: channel 1 accepted with 0x3C; `out_ready`=0 for 3 cycles while channel 0 is valid.
  - Required: `out_data`=0x3C and `out_sel`=1 held, `in_ready`=0; when `out_ready` rises, channel 0 is accepted in that same cycle with no bubble.
- Enable gating:
  - Stimulus: beat 0x77 pending; `enable`=0 with channel 3 valid.
  - Required: 0x77 drains; `in_ready` stays 0 and `out_valid` falls to 0.
- Reset mid-operation:
  - Stimulus: assert `rst` while `out_valid`=1 and stalled.
  - Required: `out_valid`=0, `out_data`=0 and `out_sel`=0 immediately, before the next clock edge.
- Fixed-priority build (`DATA_COLLECTOR_FIXED_PRIO_EN` defined):
  - Stimulus: channels 0 and 3 valid continuously.
  - Required: `out_sel`=0 on every beat; channel 3 is never granted.
